// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM responder: word-organised array with byte/halfword/word lanes,
// configurable data-phase wait states and two-cycle ERROR responses.
module ahbl_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StErr1 = 2'd2;
  localparam logic [1:0] StErr2 = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      size_q, size_d;
  logic            write_q, write_d;
  // Set while a legal data phase is outstanding (WAIT cycles plus final cycle).
  logic            dp_q, dp_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        ready_out;
  logic        accept;
  logic        illegal;
  logic        commit;
  logic        rd_phase;
  logic [3:0]  be;
  logic [31:0] word_addr;

  // Upper address bits and HTRANS[0] carry no meaning for this responder.
  logic unused_ok;
  assign unused_ok = ^{HADDR[31:16], HTRANS[0]};

  assign word_addr = {18'd0, HADDR[15:2]};
  assign ready_out = (state_q != StWait) && (state_q != StErr1);
  assign accept    = HSEL & HREADY & HTRANS[1] & ready_out;
  assign illegal   = (word_addr >= DEPTH_WORDS) ||
                     (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  // Final data-phase cycle is the one where a pending access sits in IDLE.
  assign commit   = dp_q & write_q & (state_q == StIdle);
  assign rd_phase = dp_q & ~write_q & ((state_q == StIdle) || (state_q == StWait));

  assign HREADYOUT = ready_out;
  assign HRESP     = (state_q == StErr1) || (state_q == StErr2);
  assign HRDATA    = rd_phase ? mem_q[idx_q] : 32'h0;

  // Next-state logic: accept in any ready state, count waits, sequence errors.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    dp_d    = dp_q;
    case (state_q)
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StIdle;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        // StIdle and StErr2 both present HREADYOUT=1 and may take a new access.
        state_d = StIdle;
        dp_d    = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = StErr1;
          end else begin
            dp_d    = 1'b1;
            idx_d   = HADDR[IdxW+1:2];
            lane_d  = HADDR[1:0];
            size_d  = HSIZE[1:0];
            write_d = HWRITE;
            if (WAIT_STATES > 0) begin
              state_d = StWait;
              cnt_d   = 3'(WAIT_STATES);
            end
          end
        end
      end
    endcase
  end

  // Control state with asynchronous reset; a pending write is dropped on reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
      dp_q    <= dp_d;
    end
  end

  // Byte-lane enables from registered size and low address bits.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory array: no reset, written on the edge ending the final data phase.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Bench for ahbl_sram_slave: three instances (0, 3 and 2 wait states) on a shared
// bus, a pipelined transfer engine and a read-data scoreboard.
module tb_ahbl_sram_slave;

  typedef struct {
    bit        wr;
    bit [2:0]  size;
    bit [15:0] addr;
    bit [31:0] wdata;
    bit        err;
    bit        use_exp;
    bit [31:0] exp;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hready;
  logic [31:0] hwdata;
  logic [2:0]  hro;
  logic [2:0]  hrs;
  logic [31:0] hrd [3];
  logic [1:0]  tgt = 2'd0;

  int errors = 0;
  int checks = 0;

  op_t         ops[$];
  logic [31:0] sb_q[$];
  bit   [31:0] model [3][256];

  always #5 clk = ~clk;

  // Interconnect returns the targeted responder's ready as HREADY.
  assign hready = hro[tgt];

  ahbl_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
    .HREADYOUT(hro[0]), .HRESP(hrs[0]), .HRDATA(hrd[0])
  );

  ahbl_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
    .HREADYOUT(hro[1]), .HRESP(hrs[1]), .HRDATA(hrd[1])
  );

  ahbl_sram_slave #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HREADY(hready), .HWDATA(hwdata),
    .HREADYOUT(hro[2]), .HRESP(hrs[2]), .HRDATA(hrd[2])
  );

  function automatic int ws_of(input logic [1:0] t);
    case (t)
      2'd1:    return 3;
      2'd2:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic op_t mk(input bit wr, input bit [2:0] sz, input bit [15:0] a,
                             input bit [31:0] d, input bit err = 1'b0,
                             input bit ue = 1'b0, input bit [31:0] ex = 32'h0);
    op_t o;
    o.wr = wr; o.size = sz; o.addr = a; o.wdata = d; o.err = err;
    o.use_exp = ue; o.exp = ex;
    return o;
  endfunction

  // Reference memory update from the bus-level lane rules.
  function automatic void model_write(input logic [1:0] t, input op_t o);
    bit [31:0] w;
    w = model[t][o.addr[9:2]];
    case (o.size)
      3'd0:    w[8*o.addr[1:0] +: 8] = o.wdata[8*o.addr[1:0] +: 8];
      3'd1:    w[16*o.addr[1] +: 16] = o.wdata[16*o.addr[1] +: 16];
      default: w = o.wdata;
    endcase
    model[t][o.addr[9:2]] = w;
  endfunction

  task automatic idle_bus();
    hsel = 3'b000; htrans = 2'b00; haddr = 32'h0; hsize = 3'd2; hwrite = 1'b0;
    hwdata = 32'h0;
  endtask

  // Pipelined master: drives queued ops back to back on target t, checks each data phase.
  task automatic run_ops(input logic [1:0] t);
    op_t         ap, dp;
    bit          dp_v = 1'b0;
    int          idx = 0;
    int          cyc = 0;
    int          low = 0;
    int          exp_low;
    logic        rdy, rsp;
    logic [31:0] rd, e;
    tgt = t;
    while ((idx < ops.size() || dp_v) && cyc < 100) begin
      if (idx < ops.size()) begin
        ap = ops[idx];
        hsel = 3'b001 << t; htrans = 2'b10; haddr = {16'h0, ap.addr};
        hsize = ap.size; hwrite = ap.wr;
      end else begin
        hsel = 3'b000; htrans = 2'b00;
      end
      hwdata = (dp_v && dp.wr) ? dp.wdata : 32'h0;
      @(negedge clk);
      rdy = hro[t]; rsp = hrs[t]; rd = hrd[t];
      if (dp_v) begin
        if (!rdy) begin
          low++;
          if (dp.err) begin
            checks++;
            if (rsp !== 1'b1 || rd !== 32'h0) begin
              errors++;
              $display("FAIL err1_phase: got resp=%b rdata=%h want resp=1 rdata=0", rsp, rd);
            end
          end
        end else begin
          exp_low = dp.err ? 1 : ws_of(t);
          checks++;
          if (rsp !== dp.err) begin
            errors++;
            $display("FAIL hresp @%h: got %b want %b", dp.addr, rsp, dp.err);
          end
          checks++;
          if (low != exp_low) begin
            errors++;
            $display("FAIL wait_cycles @%h: got %0d want %0d", dp.addr, low, exp_low);
          end
          if (!dp.wr && !dp.err) begin
            e = sb_q.pop_front();
            checks++;
            if (rd !== e) begin
              errors++;
              $display("FAIL rdata @%h: got %h want %h", dp.addr, rd, e);
            end
          end
          dp_v = 1'b0;
        end
      end
      if (rdy && idx < ops.size()) begin
        if (!ap.err) begin
          if (ap.wr) model_write(t, ap);
          else sb_q.push_back(ap.use_exp ? ap.exp : model[t][ap.addr[9:2]]);
        end
        dp = ap; dp_v = 1'b1; low = 0; idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d cycles want <100", cyc);
    end
    idle_bus();
    ops.delete();
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hro[i] !== 1'b1 || hrs[i] !== 1'b0 || hrd[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b/%b/%h want 1/0/00000000",
                 i, hro[i], hrs[i], hrd[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    ops.push_back(mk(1'b1, 3'd2, 16'h0010, 32'hA5A5_1234));
    ops.push_back(mk(1'b0, 3'd2, 16'h0010, 32'h0, 1'b0, 1'b1, 32'hA5A5_1234));
    run_ops(2'd0);
  endtask

  task automatic test_lanes();
    ops.push_back(mk(1'b1, 3'd2, 16'h0020, 32'hFFFF_FFFF));
    ops.push_back(mk(1'b1, 3'd0, 16'h0022, 32'h005A_0000));
    ops.push_back(mk(1'b1, 3'd1, 16'h0020, 32'h0000_BEEF));
    ops.push_back(mk(1'b0, 3'd2, 16'h0020, 32'h0, 1'b0, 1'b1, 32'hFF5A_BEEF));
    ops.push_back(mk(1'b1, 3'd0, 16'h0027, 32'h7700_0000));
    ops.push_back(mk(1'b1, 3'd1, 16'h0024, 32'h1234_0000));
    ops.push_back(mk(1'b0, 3'd0, 16'h0024, 32'h0));
    run_ops(2'd0);
  endtask

  task automatic test_waits();
    ops.push_back(mk(1'b1, 3'd2, 16'h0004, 32'h1234_5678));
    ops.push_back(mk(1'b0, 3'd2, 16'h0004, 32'h0, 1'b0, 1'b1, 32'h1234_5678));
    ops.push_back(mk(1'b1, 3'd0, 16'h0005, 32'h0000_9900));
    ops.push_back(mk(1'b0, 3'd2, 16'h0004, 32'h0, 1'b0, 1'b1, 32'h1234_9978));
    run_ops(2'd1);
  endtask

  task automatic test_errors();
    ops.push_back(mk(1'b1, 3'd2, 16'h0000, 32'hCAFE_0000));
    ops.push_back(mk(1'b1, 3'd2, 16'h0400, 32'hFFFF_FFFF, 1'b1));
    ops.push_back(mk(1'b1, 3'd1, 16'h0003, 32'hFFFF_FFFF, 1'b1));
    ops.push_back(mk(1'b1, 3'd2, 16'h0002, 32'hFFFF_FFFF, 1'b1));
    ops.push_back(mk(1'b0, 3'd3, 16'h0000, 32'h0, 1'b1));
    ops.push_back(mk(1'b0, 3'd2, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hCAFE_0000));
    run_ops(2'd0);
  endtask

  task automatic test_idle_busy();
    ops.push_back(mk(1'b1, 3'd2, 16'h0030, 32'h0102_0304));
    run_ops(2'd0);
    // BUSY then IDLE with HSEL high: zero-wait OKAY, no access.
    hsel = 3'b001; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    @(negedge clk);
    checks++;
    if (hro[0] !== 1'b1 || hrs[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_resp: got %b/%b want 1/0", hro[0], hrs[0]);
    end
    @(posedge clk); #1;
    hwdata = 32'hFFFF_FFFF; htrans = 2'b00;
    @(negedge clk);
    checks++;
    if (hro[0] !== 1'b1 || hrs[0] !== 1'b0 || hrd[0] !== 32'h0) begin
      errors++;
      $display("FAIL idle_resp: got %b/%b/%h want 1/0/00000000", hro[0], hrs[0], hrd[0]);
    end
    @(posedge clk); #1;
    // NONSEQ write with HSEL low must be ignored.
    hsel = 3'b000; htrans = 2'b10; hwrite = 1'b1; hwdata = 32'h0;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (hro[0] !== 1'b1 || hrd[0] !== 32'h0) begin
      errors++;
      $display("FAIL unselected: got %b/%h want 1/00000000", hro[0], hrd[0]);
    end
    @(posedge clk); #1;
    idle_bus();
    ops.push_back(mk(1'b0, 3'd2, 16'h0030, 32'h0, 1'b0, 1'b1, 32'h0102_0304));
    run_ops(2'd0);
  endtask

  task automatic test_reset_mid();
    ops.push_back(mk(1'b1, 3'd2, 16'h0008, 32'h1111_1111));
    run_ops(2'd2);
    tgt = 2'd2;
    hsel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 3'b000; htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (hro[2] !== 1'b0) begin
      errors++;
      $display("FAIL wait_before_reset: got %b want 0", hro[2]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (hro[2] !== 1'b1 || hrs[2] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %b/%b want 1/0", hro[2], hrs[2]);
    end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    ops.push_back(mk(1'b0, 3'd2, 16'h0008, 32'h0, 1'b0, 1'b1, 32'h1111_1111));
    ops.push_back(mk(1'b1, 3'd1, 16'h000A, 32'h2222_0000));
    ops.push_back(mk(1'b0, 3'd2, 16'h0008, 32'h0, 1'b0, 1'b1, 32'h2222_1111));
    run_ops(2'd2);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_bus();
    test_reset();
    test_back_to_back();
    test_lanes();
    test_waits();
    test_errors();
    test_idle_busy();
    test_reset_mid();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahbl_sram_slave.md
Name: ahbl_sram_slave

Overview:
AHB-Lite responder (slave) backed by an internal word-organised memory array, with configurable data-phase wait states and ERROR responses for illegal accesses. It is the target side of the protocol that the DMA master drives. Benches use it as the DMA's source and destination memory, and SoC builds use it as scratch RAM. It supports byte, halfword and word transfers with correct byte-lane handling.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; legal range 1..16384.
WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase; legal range 0..7.

Ports:
HCLK  input  1  clock; all logic on the rising edge.
HRESETn  input  1  reset, asynchronous assert, active-low.
HSEL  input  1  slave select from the address decoder.
HADDR  input  32  address; only HADDR[15:0] is used.
HTRANS  input  2  transfer type; bit 1 set means NONSEQ or SEQ.
HSIZE  input  3  transfer size: 0 byte, 1 halfword, 2 word.
HWRITE  input  1  1 = write.
HREADY  input  1  bus-level ready; the address phase is valid only when this is high.
HWDATA  input  32  write data, sampled in the data phase.
HREADYOUT  output  1  slave ready.
HRESP  output  1  0 OKAY, 1 ERROR.
HRDATA  output  32  read data.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM in IDLE. Reset has no effect on memory contents.
- Accept condition: an address phase is accepted when HSEL & HREADY & HTRANS[1]. Accepting registers HADDR[15:0], HSIZE and HWRITE.
- IDLE and BUSY transfers, or HSEL=0, produce no access. The slave responds zero-wait OKAY.
- An access is illegal if any of the following holds:
  - HADDR[15:2] >= DEPTH_WORDS
  - HSIZE > 2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0]!=0
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted legal access with WAIT_STATES>0 → WAIT; the wait counter loads WAIT_STATES.
    - Accepted legal access with WAIT_STATES=0 → stay IDLE; the data phase completes in the next cycle.
    - Accepted illegal access → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle. When it reaches 1, the next cycle is the final data-phase cycle, with HREADYOUT=1 and state IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 → IDLE. A new address phase presented during ERR2 is accepted normally; the master may also cancel with IDLE.
- Latency: an OKAY data phase lasts WAIT_STATES+1 cycles. An ERROR data phase always lasts exactly 2 cycles, and WAIT_STATES does not apply.
- Writes:
  - HWDATA is sampled and committed on the clock edge that ends the final data-phase cycle (HREADYOUT=1, HRESP=0).
  - Byte: lane HADDR[1:0] only.
  - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all 4 lanes.
  - Lanes that are not written keep their value.
  - Illegal writes never modify memory.
- Reads:
  - During a read data phase, HRDATA is combinationally equal to mem[registered word index], full 32 bits. The master selects the lane.
  - HRDATA is 0 outside read data phases and during ERR1/ERR2.
- Back-to-back: a read that immediately follows a write to the same word returns the newly written data. This holds at zero wait states, because the commit edge precedes the read data phase.
- Pipelining: no new address phase is accepted while HREADYOUT=0. Accepting requires HREADY, which the interconnect drives from this HREADYOUT.
- Reset mid-transfer: the FSM returns to IDLE, any pending write is discarded, and outputs go to their reset values immediately.
- HADDR[31:16] are ignored; address decoding is external.

Test Plan:
1. WAIT_STATES=0: word write 0xA5A5_1234 to 0x10, then read 0x10 on the next cycle → HREADYOUT stays 1 throughout; HRDATA=0xA5A51234 in the read data phase.
2. Preload word 0x20=0xFFFFFFFF, then byte write 0x5A to 0x22 and halfword write 0xBEEF to 0x20 → a read of 0x20 returns 0xFF5ABEEF.
3. WAIT_STATES=3: a read of 0x4 shows HREADYOUT low for exactly 3 cycles, then high for 1 cycle with valid HRDATA. A NONSEQ held on the bus during the waits is accepted only in the ready cycle.
4. DEPTH_WORDS=256: write to 0x400 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1), then IDLE. Memory word 0 is unchanged. The same two-cycle ERROR sequence occurs for a halfword at 0x3 and a word at 0x2.
5. BUSY and IDLE HTRANS with HSEL=1 → zero-wait OKAY and no memory change. NONSEQ with HSEL=0 → ignored.
6. Assert HRESETn=0 during a WAIT_STATES=2 write → HREADYOUT=1 and HRESP=0 immediately. The target word is unchanged after reset deasserts, and the next access completes normally.
